// File: rtl/mips_mmio_display.sv
// Memory-mapped LED / 4-digit 7-segment display controller on the MIPS data bus.
// Decodes stores into a 16-byte I/O window and time-multiplexes the digits.
module mips_mmio_display #(
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWrite,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWData,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic [7:0]  HEX,
  output logic [3:0]  HEX_DIGIT,
  output logic [9:0]  LED
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(REFRESH_DIV - 1);

  logic [9:0]    led_q;
  logic [15:0]   hexval_q;
  logic [7:0]    ctrl_q;
  logic [31:0]   tick_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    scan_q;
  logic [7:0]    hex_q, hex_d;
  logic [3:0]    digit_q, digit_d;

  logic       wr;
  logic       term;
  logic [3:0] nibble;

  logic unused_bits;
  assign unused_bits = ^{MemWData[31:16], MemAddr[1:0]};

  assign io_sel = (MemAddr[31:4] == IO_BASE[31:4]);
  assign wr     = MemWrite && io_sel;
  assign term   = (presc_q == PrescLast);
  assign LED    = led_q;
  assign HEX    = hex_q;
  assign HEX_DIGIT = digit_q;

  // Segment pattern {g..a}, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    io_rdata = '0;
    if (io_sel) begin
      case (MemAddr[3:2])
        2'd0:    io_rdata = {22'b0, led_q};
        2'd1:    io_rdata = {16'b0, hexval_q};
        2'd2:    io_rdata = {24'b0, ctrl_q};
        default: io_rdata = tick_q;
      endcase
    end
  end

  always_comb begin
    nibble  = hexval_q[4*scan_q +: 4];
    hex_d   = 8'hFF;
    digit_d = 4'hF;
    if (ctrl_q[scan_q]) begin
      digit_d         = ~(4'b0001 << scan_q);
      hex_d           = {~ctrl_q[4 + scan_q], seg7(nibble)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= '0;
      hexval_q <= '0;
      ctrl_q   <= 8'h0F;
      tick_q   <= '0;
      presc_q  <= '0;
      scan_q   <= '0;
      hex_q    <= 8'hFF;
      digit_q  <= 4'hF;
    end else begin
      hex_q   <= hex_d;
      digit_q <= digit_d;
      presc_q <= term ? '0 : presc_q + 1'b1;
      if (term) scan_q <= scan_q + 2'd1;
      // A store to TICK overrides a same-edge increment.
      if (wr && MemAddr[3:2] == 2'd3) tick_q <= '0;
      else if (term)                  tick_q <= tick_q + 32'd1;
      if (wr && MemAddr[3:2] == 2'd0) led_q    <= MemWData[9:0];
      if (wr && MemAddr[3:2] == 2'd1) hexval_q <= MemWData[15:0];
      if (wr && MemAddr[3:2] == 2'd2) ctrl_q   <= MemWData[7:0];
    end
  end

endmodule

// File: tb/tb_mips_mmio_display.sv
// Scoreboard bench for mips_mmio_display: the driver queues expected values tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_mips_mmio_display;

  localparam int SigHex = 0, SigDig = 1, SigLed = 2, SigRd = 3, SigSel = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        io_sel;
  logic [31:0] io_rdata;
  logic [7:0]  HEX;
  logic [3:0]  HEX_DIGIT;
  logic [9:0]  LED;

  mips_mmio_display #(
    .IO_BASE    (32'hFFFF_0000),
    .REFRESH_DIV(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemWrite (MemWrite),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .io_sel   (io_sel),
    .io_rdata (io_rdata),
    .HEX      (HEX),
    .HEX_DIGIT(HEX_DIGIT),
    .LED      (LED)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      SigHex:  return {24'b0, HEX};
      SigDig:  return {28'b0, HEX_DIGIT};
      SigLed:  return {22'b0, LED};
      SigRd:   return io_rdata;
      default: return {31'b0, io_sel};
    endcase
  endfunction

  task automatic push(input int c, input int sig, input logic [31:0] exp, input string name);
    exp_t e;
    e.c = c; e.sig = sig; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  exp_t        cur;
  logic [31:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      cur = sb.pop_front();
      n_vec++;
      act = sample(cur.sig);
      if (cur.c != cyc) begin
        n_err++;
        $display("FAIL %s: check for cycle %0d reached only at cycle %0d", cur.name, cur.c, cyc);
      end else if (act !== cur.exp) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got %h, expected %h", cur.name, cyc, act, cur.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    rst_n = 1'b0; MemWrite = 1'b0; MemAddr = '0; MemWData = '0;
    wait_cyc(2);
    // Reset state, then one-slot-per-4-cycles scan after release (release edge 1 = cycle 3).
    push(2, SigHex, 32'hFF, "rst_hex");
    push(2, SigDig, 32'hF,  "rst_digit");
    push(2, SigLed, 32'h0,  "rst_led");
    push(2, SigRd,  32'h0,  "rst_rdata_out_of_window");
    push(2, SigSel, 32'h0,  "rst_io_sel");
    push(3, SigHex, 32'hC0, "first_hex");
    push(3, SigDig, 32'hE,  "first_digit");
    push(7,  SigDig, 32'hD, "scan_d1");
    push(11, SigDig, 32'hB, "scan_d2");
    push(15, SigDig, 32'h7, "scan_d3");
    push(19, SigDig, 32'hE, "scan_wrap");
    rst_n = 1'b1;

    wait_cyc(22);
    MemAddr = 32'hFFFF_000C;
    push(22, SigRd, 32'd5, "tick_after_20");

    // Clear TICK on a terminal-count edge (edge 24 after release).
    wait_cyc(25);
    MemWrite = 1'b1; MemWData = 32'hDEAD_BEEF;
    push(25, SigSel, 32'h1, "tick_store_io_sel");
    push(25, SigRd,  32'd5, "tick_before_clear");
    wait_cyc(26);
    MemWrite = 1'b0;
    push(26, SigRd, 32'd0, "tick_clear_wins");
    wait_cyc(30);
    push(30, SigRd, 32'd1, "tick_after_clear");

    wait_cyc(31);
    MemWrite = 1'b1; MemAddr = 32'hFFFF_0004; MemWData = 32'h0000_1234;
    push(31, SigSel, 32'h1, "hexval_io_sel");
    push(31, SigRd,  32'h0, "hexval_old_on_store");
    wait_cyc(32);
    MemWrite = 1'b0;
    push(32, SigRd, 32'h1234, "hexval_readback");
    push(35, SigHex, 32'h99, "hex_d0");
    push(35, SigDig, 32'hE,  "dig_d0");
    push(39, SigHex, 32'hB0, "hex_d1");
    push(39, SigDig, 32'hD,  "dig_d1");
    push(43, SigHex, 32'hA4, "hex_d2");
    push(43, SigDig, 32'hB,  "dig_d2");
    push(47, SigHex, 32'hF9, "hex_d3");
    push(47, SigDig, 32'h7,  "dig_d3");

    wait_cyc(51);
    MemWrite = 1'b1; MemAddr = 32'hFFFF_0000; MemWData = 32'hFFFF_FFFF;
    push(51, SigLed, 32'h0, "led_before_edge");
    push(51, SigRd,  32'h0, "led_old_on_store");
    wait_cyc(52);
    MemWrite = 1'b0;
    push(52, SigLed, 32'h3FF, "led_at_edge");
    push(52, SigRd,  32'h3FF, "led_readback");

    wait_cyc(53);
    MemWrite = 1'b1; MemAddr = 32'hFFFF_0008; MemWData = 32'h0000_0015;
    wait_cyc(54);
    MemWrite = 1'b0;
    push(54, SigRd,  32'h15, "ctrl_readback");
    push(55, SigHex, 32'hFF, "blank_hex_d1");
    push(55, SigDig, 32'hF,  "blank_dig_d1");
    push(59, SigHex, 32'hA4, "ctrl_hex_d2");
    push(59, SigDig, 32'hB,  "ctrl_dig_d2");
    push(63, SigHex, 32'hFF, "blank_hex_d3");
    push(63, SigDig, 32'hF,  "blank_dig_d3");
    push(67, SigHex, 32'h19, "dp_hex_d0");
    push(67, SigDig, 32'hE,  "dp_dig_d0");

    // Out-of-window store whose low bits alias the LED register.
    wait_cyc(68);
    MemWrite = 1'b1; MemAddr = 32'h0001_0040; MemWData = 32'h0;
    push(68, SigSel, 32'h0, "oow_io_sel");
    push(68, SigRd,  32'h0, "oow_rdata");
    wait_cyc(69);
    MemWrite = 1'b0; MemAddr = 32'hFFFF_0000;
    push(69, SigRd,  32'h3FF, "oow_led_kept");
    push(69, SigLed, 32'h3FF, "oow_led_pin");
    wait_cyc(70);
    MemAddr = 32'hFFFF_0004;
    push(70, SigRd, 32'h1234, "oow_hexval_kept");

    // Asynchronous reset mid-slot, checked before the next rising edge.
    wait_cyc(75);
    rst_n = 1'b0;
    push(75, SigHex, 32'hFF, "async_rst_hex");
    push(75, SigDig, 32'hF,  "async_rst_digit");
    push(75, SigLed, 32'h0,  "async_rst_led");
    push(75, SigRd,  32'h0,  "async_rst_hexval");

    repeat (3) step();
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: never checked, expected %h", cur.name, cur.exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
